// File: rtl/oven_cook_sequencer.sv
// Cook-cycle controller: preheat to target, bake countdown on a 1 Hz tick,
// timed done alarm, preheat-timeout fault, and bang-bang heater control with
// hysteresis. Every output is a flop updated from the next-state decision.
module oven_cook_sequencer #(
  parameter int TEMP_W          = 10,
  parameter int TIME_W          = 13,
  parameter int HYST            = 5,
  parameter int PREHEAT_MARGIN  = 10,
  parameter int PREHEAT_TIMEOUT = 900,
  parameter int ALARM_SECS      = 10,
  parameter int MIN_TEMP        = 65,
  parameter int MAX_TEMP        = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              start,
  input  logic              cancel,
  input  logic [TEMP_W-1:0] target_temp,
  input  logic [TIME_W-1:0] target_time,
  input  logic [TEMP_W-1:0] current_temp,
  output logic              heat,
  output logic              preheated,
  output logic              alarm,
  output logic              fault,
  output logic              busy,
  output logic [2:0]        state,
  output logic [TIME_W-1:0] remaining_time
);

  localparam int PT_W = $clog2(PREHEAT_TIMEOUT + 1);
  localparam int AL_W = $clog2(ALARM_SECS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREHEAT = 3'd1,
    S_BAKE    = 3'd2,
    S_DONE    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t              cur;
  state_t              nxt;
  logic [TEMP_W-1:0]   t_lat;
  logic [TEMP_W-1:0]   t_lat_nxt;
  logic [TIME_W-1:0]   remaining_nxt;
  logic [PT_W-1:0]     pre_timer;
  logic [PT_W-1:0]     pre_timer_nxt;
  logic [AL_W-1:0]     alarm_cnt;
  logic [AL_W-1:0]     alarm_cnt_nxt;
  logic                heat_nxt;
  logic [TEMP_W-1:0]   threshold;
  logic [TEMP_W:0]     heat_off_lim;
  logic                start_ok;
  logic                heating_now;
  logic                heating_next;

  // Threshold below target; clamps at zero instead of wrapping for tiny targets.
  function automatic logic [TEMP_W-1:0] sat_sub(input logic [TEMP_W-1:0] a,
                                                input logic [TEMP_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  // One extra bit keeps target + hysteresis from wrapping near full scale.
  function automatic logic [TEMP_W:0] wide_add(input logic [TEMP_W-1:0] a,
                                               input logic [TEMP_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign threshold    = sat_sub(t_lat, TEMP_W'(PREHEAT_MARGIN));
  assign heat_off_lim = wide_add(t_lat, TEMP_W'(HYST));
  assign start_ok     = (target_temp >= TEMP_W'(MIN_TEMP)) &&
                        (target_temp <= TEMP_W'(MAX_TEMP)) &&
                        (target_time != '0);
  assign heating_now  = (cur == S_PREHEAT) || (cur == S_BAKE);
  assign heating_next = (nxt == S_PREHEAT) || (nxt == S_BAKE);
  assign state        = cur;

  // Next-state and counter decisions; priority is cancel, then start, then tick.
  always_comb begin
    nxt           = cur;
    t_lat_nxt     = t_lat;
    remaining_nxt = remaining_time;
    pre_timer_nxt = pre_timer;
    alarm_cnt_nxt = alarm_cnt;
    if (cancel && (cur != S_IDLE)) begin
      nxt           = S_IDLE;
      remaining_nxt = '0;
      pre_timer_nxt = '0;
      alarm_cnt_nxt = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start && !cancel && start_ok) begin
            t_lat_nxt     = target_temp;
            remaining_nxt = target_time;
            pre_timer_nxt = '0;
            nxt           = S_PREHEAT;
          end
        end
        S_PREHEAT: begin
          // Reaching temperature beats a simultaneous timeout tick.
          if (current_temp >= threshold) begin
            nxt = S_BAKE;
          end else if (tick_1hz) begin
            pre_timer_nxt = pre_timer + PT_W'(1);
            if (pre_timer_nxt == PT_W'(PREHEAT_TIMEOUT)) nxt = S_FAULT;
          end
        end
        S_BAKE: begin
          if (tick_1hz) begin
            remaining_nxt = remaining_time - TIME_W'(1);
            if (remaining_time == TIME_W'(1)) begin
              nxt           = S_DONE;
              alarm_cnt_nxt = AL_W'(ALARM_SECS);
            end
          end
        end
        S_DONE: begin
          if (tick_1hz) begin
            alarm_cnt_nxt = alarm_cnt - AL_W'(1);
            if (alarm_cnt == AL_W'(1)) nxt = S_IDLE;
          end
        end
        S_FAULT: nxt = S_FAULT;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Bang-bang heater: on below target, off at target+HYST, hold in between.
  // Forced off on the edge that leaves PREHEAT/BAKE and on the edge entering PREHEAT.
  always_comb begin
    heat_nxt = 1'b0;
    if (heating_now && heating_next) begin
      if (current_temp < t_lat)                     heat_nxt = 1'b1;
      else if ({1'b0, current_temp} >= heat_off_lim) heat_nxt = 1'b0;
      else                                           heat_nxt = heat;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur            <= S_IDLE;
      t_lat          <= '0;
      remaining_time <= '0;
      pre_timer      <= '0;
      alarm_cnt      <= '0;
      heat           <= 1'b0;
      preheated      <= 1'b0;
      alarm          <= 1'b0;
      fault          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      cur            <= nxt;
      t_lat          <= t_lat_nxt;
      remaining_time <= remaining_nxt;
      pre_timer      <= pre_timer_nxt;
      alarm_cnt      <= alarm_cnt_nxt;
      heat           <= heat_nxt;
      preheated      <= (nxt == S_BAKE);
      alarm          <= (nxt == S_DONE);
      fault          <= (nxt == S_FAULT);
      busy           <= heating_next;
    end
  end

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Scoreboard bench for oven_cook_sequencer: stimulus queues hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_oven_cook_sequencer;

  localparam int TEMP_W = 10;
  localparam int TIME_W = 13;

  localparam int SIG_STATE = 0;
  localparam int SIG_HEAT  = 1;
  localparam int SIG_PRE   = 2;
  localparam int SIG_ALARM = 3;
  localparam int SIG_FAULT = 4;
  localparam int SIG_BUSY  = 5;
  localparam int SIG_REM   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick_1hz = 1'b0;
  logic              start = 1'b0;
  logic              cancel = 1'b0;
  logic [TEMP_W-1:0] target_temp = '0;
  logic [TIME_W-1:0] target_time = '0;
  logic [TEMP_W-1:0] current_temp = '0;
  logic              heat, preheated, alarm, fault, busy;
  logic [2:0]        state;
  logic [TIME_W-1:0] remaining_time;

  typedef struct {
    int    cyc;
    string name;
    int    sig;
    int    val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  oven_cook_sequencer #(
    .TEMP_W(TEMP_W), .TIME_W(TIME_W), .HYST(5), .PREHEAT_MARGIN(10),
    .PREHEAT_TIMEOUT(4), .ALARM_SECS(10), .MIN_TEMP(65), .MAX_TEMP(500)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .cancel(cancel),
    .target_temp(target_temp), .target_time(target_time), .current_temp(current_temp),
    .heat(heat), .preheated(preheated), .alarm(alarm), .fault(fault), .busy(busy),
    .state(state), .remaining_time(remaining_time)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sig);
    case (sig)
      SIG_STATE: return int'(state);
      SIG_HEAT:  return int'(heat);
      SIG_PRE:   return int'(preheated);
      SIG_ALARM: return int'(alarm);
      SIG_FAULT: return int'(fault);
      SIG_BUSY:  return int'(busy);
      default:   return int'(remaining_time);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_STATE: return "state";
      SIG_HEAT:  return "heat";
      SIG_PRE:   return "preheated";
      SIG_ALARM: return "alarm";
      SIG_FAULT: return "fault";
      SIG_BUSY:  return "busy";
      default:   return "remaining_time";
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      checks++;
      a = actual(e.sig);
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL %s: %s expectation for cycle %0d not checked in time (now %0d)",
                 e.name, sig_name(e.sig), e.cyc, cyc);
      end else if ($isunknown(actual(e.sig)) || a != e.val) begin
        fails++;
        $display("FAIL %s: %s got %0d, expected %0d", e.name, sig_name(e.sig), a, e.val);
      end
    end
  end

  // One clock edge with the given single-cycle pulses applied.
  task automatic edge_(input bit s = 0, input bit c = 0, input bit t = 0);
    start = s; cancel = c; tick_1hz = t;
    @(posedge clk); #1;
    start = 0; cancel = 0; tick_1hz = 0;
  endtask

  // Expectation about the outputs following the most recent edge.
  task automatic expect_(input string n, input int sig, input int val);
    exp_t e;
    e.cyc = cyc; e.name = n; e.sig = sig; e.val = val;
    q.push_back(e);
  endtask

  task automatic expect_all_idle(input string n);
    expect_(n, SIG_STATE, 0); expect_(n, SIG_HEAT, 0); expect_(n, SIG_PRE, 0);
    expect_(n, SIG_ALARM, 0); expect_(n, SIG_FAULT, 0); expect_(n, SIG_BUSY, 0);
    expect_(n, SIG_REM, 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    edge_();
    expect_all_idle("reset");
    rst = 1'b0;
    edge_();
    expect_("idle_after_reset", SIG_STATE, 0);

    // Valid cook with immediate preheat: 350 F, 3 s, oven at 345
    target_temp = 350; target_time = 3; current_temp = 345;
    edge_(1);
    expect_("cook_preheat", SIG_STATE, 1); expect_("cook_preheat", SIG_BUSY, 1);
    expect_("cook_preheat", SIG_HEAT, 0);  expect_("cook_preheat", SIG_REM, 3);
    edge_();
    expect_("cook_bake", SIG_STATE, 2); expect_("cook_bake", SIG_PRE, 1);
    expect_("cook_bake", SIG_HEAT, 1);  expect_("cook_bake", SIG_REM, 3);
    edge_(0, 0, 1);
    expect_("cook_tick1", SIG_REM, 2); expect_("cook_tick1", SIG_STATE, 2);
    edge_(0, 0, 1);
    expect_("cook_tick2", SIG_REM, 1);
    edge_(0, 0, 1);
    expect_("cook_done", SIG_REM, 0);   expect_("cook_done", SIG_STATE, 3);
    expect_("cook_done", SIG_ALARM, 1); expect_("cook_done", SIG_BUSY, 0);
    expect_("cook_done", SIG_HEAT, 0);  expect_("cook_done", SIG_PRE, 0);
    edge_(1);
    expect_("start_in_done", SIG_STATE, 3);
    for (int i = 1; i <= 9; i++) edge_(0, 0, 1);
    expect_("alarm_9_ticks", SIG_ALARM, 1); expect_("alarm_9_ticks", SIG_STATE, 3);
    edge_(0, 0, 1);
    expect_("alarm_end", SIG_ALARM, 0); expect_("alarm_end", SIG_STATE, 0);

    // Invalid start requests
    target_temp = 350; target_time = 0;
    edge_(1);
    expect_("bad_time0", SIG_STATE, 0); expect_("bad_time0", SIG_BUSY, 0);
    target_temp = 40; target_time = 5;
    edge_(1);
    expect_("bad_temp40", SIG_STATE, 0); expect_("bad_temp40", SIG_BUSY, 0);
    target_temp = 600;
    edge_(1);
    expect_("bad_temp600", SIG_STATE, 0); expect_("bad_temp600", SIG_BUSY, 0);

    // Boundary target 65 accepted; cancel beats the met preheat threshold
    target_temp = 65; target_time = 1;
    edge_(1);
    expect_("min_temp_ok", SIG_STATE, 1); expect_("min_temp_ok", SIG_REM, 1);
    edge_(0, 1);
    expect_("cancel_preheat", SIG_STATE, 0); expect_("cancel_preheat", SIG_REM, 0);

    // Hysteresis sweep at 300 F
    target_temp = 300; target_time = 100; current_temp = 290;
    edge_(1);
    expect_("hyst_preheat", SIG_STATE, 1); expect_("hyst_preheat", SIG_HEAT, 0);
    target_temp = 0; target_time = 0;
    edge_();
    expect_("hyst_bake", SIG_STATE, 2); expect_("hyst_bake", SIG_HEAT, 1);
    current_temp = 299; edge_(); expect_("hyst_299", SIG_HEAT, 1);
    current_temp = 300; edge_(); expect_("hyst_300", SIG_HEAT, 1);
    current_temp = 304; edge_(); expect_("hyst_304", SIG_HEAT, 1);
    current_temp = 305; edge_(); expect_("hyst_305", SIG_HEAT, 0);
    current_temp = 302; edge_(); expect_("hyst_302", SIG_HEAT, 0);
    current_temp = 299; edge_(); expect_("hyst_299b", SIG_HEAT, 1);
    expect_("hyst_rem_hold", SIG_REM, 100);
    edge_(0, 1);
    expect_("hyst_cancel", SIG_STATE, 0); expect_("hyst_cancel", SIG_HEAT, 0);

    // Preheat timeout (timeout of 4 ticks)
    target_temp = 400; target_time = 5; current_temp = 100;
    edge_(1);
    expect_("to_preheat", SIG_STATE, 1);
    for (int i = 1; i <= 3; i++) edge_(0, 0, 1);
    expect_("to_3ticks", SIG_STATE, 1); expect_("to_3ticks", SIG_HEAT, 1);
    edge_(0, 0, 1);
    expect_("to_fault", SIG_STATE, 4); expect_("to_fault", SIG_FAULT, 1);
    expect_("to_fault", SIG_HEAT, 0);  expect_("to_fault", SIG_BUSY, 0);
    edge_(1);
    expect_("fault_start", SIG_STATE, 4); expect_("fault_start", SIG_FAULT, 1);
    edge_(0, 1);
    expect_("fault_cancel", SIG_STATE, 0); expect_("fault_cancel", SIG_FAULT, 0);

    // Threshold met on the timeout tick: BAKE wins
    edge_(1);
    for (int i = 1; i <= 3; i++) edge_(0, 0, 1);
    current_temp = 390;
    edge_(0, 0, 1);
    expect_("tie_bake", SIG_STATE, 2); expect_("tie_bake", SIG_FAULT, 0);
    edge_(0, 1);
    expect_("tie_cancel", SIG_STATE, 0);

    // Mid-bake cancel coincident with a tick
    target_temp = 350; target_time = 5; current_temp = 345;
    edge_(1);
    edge_();
    expect_("mb_bake", SIG_STATE, 2);
    for (int i = 1; i <= 3; i++) edge_(0, 0, 1);
    expect_("mb_rem2", SIG_REM, 2);
    edge_(0, 1, 1);
    expect_("mb_cancel", SIG_STATE, 0); expect_("mb_cancel", SIG_REM, 0);
    expect_("mb_cancel", SIG_HEAT, 0);  expect_("mb_cancel", SIG_ALARM, 0);

    // Reset during PREHEAT, with a start on the same edge
    target_temp = 400; current_temp = 100;
    edge_(1);
    edge_();
    expect_("rp_preheat", SIG_STATE, 1); expect_("rp_preheat", SIG_HEAT, 1);
    rst = 1'b1;
    edge_(1);
    expect_all_idle("rp_reset");
    rst = 1'b0;
    edge_();
    expect_("rp_after", SIG_STATE, 0); expect_("rp_after", SIG_BUSY, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
